crew_status_scheduler: RTL and testbench

Round-robin scheduler that shares one `personnel_processor` risk scorer among `N_STATIONS` crew-reporting stations. It arbitrates station requests and drives the scorer's `crew_status` input with the winner's snapshot. It captures the scorer's `risk_score` after the scorer's registered latency and returns the result to the requester with a single-cycle ack. It sits between the station interfaces and the scorer, and also maintains a sticky critical-crew alarm and an optional per-station staleness watchdog.

---
 rtl/crew_status_scheduler_if.sv | 27 ++
 rtl/crew_status_scheduler.sv | 156 +++++++++++++++
 tb/tb_crew_status_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/crew_status_scheduler_if.sv
// Station-side bus of the crew status scheduler.
// The master modport belongs to the station cluster; the slave modport belongs to the scheduler.
interface crew_status_scheduler_if #(
  parameter int N_STATIONS = 4
);
  localparam int IW = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;

  logic [N_STATIONS-1:0]   req;
  logic [8*N_STATIONS-1:0] status_in;
  logic                    alarm_clr;
  logic [N_STATIONS-1:0]   ack;
  logic                    score_valid;
  logic [15:0]             score_out;
  logic [IW-1:0]           score_station;
  logic                    crit_alarm;
  logic [N_STATIONS-1:0]   stale;

  modport master (
    output req, status_in, alarm_clr,
    input  ack, score_valid, score_out, score_station, crit_alarm, stale
  );

  modport slave (
    input  req, status_in, alarm_clr,
    output ack, score_valid, score_out, score_station, crit_alarm, stale
  );
endinterface

// File: rtl/crew_status_scheduler.sv
// Round-robin scheduler sharing one risk scorer among N_STATIONS crew stations.
// A transaction takes three cycles: IDLE (grant and snapshot), SETTLE (scorer samples),
// CAPTURE (score registered, ack pulsed). A sticky alarm latches scores of 16'h8000.
// Optional per-station staleness watchdog is built when CREW_SCHED_WATCHDOG_EN is defined;
// otherwise the stale flags are tied to 0.
module crew_status_scheduler #(
  parameter int N_STATIONS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  crew_status_scheduler_if.slave  bus,
  output logic [7:0]              o_proc_status,
  input  logic [15:0]             i_proc_score
);

  localparam int IW = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_idx;
  logic [7:0]            r_proc_status;
  logic [15:0]           r_score_out;
  logic [IW-1:0]         r_score_station;
  logic [N_STATIONS-1:0] r_ack;
  logic                  r_score_valid;
  logic                  r_crit_alarm;

  logic                  w_any;
  logic [IW-1:0]         w_winner;
  logic [7:0]            w_status_sel;
  logic                  w_capture;

  // Station index reached k steps after the pointer, wrapping around the ring.
  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % N_STATIONS;
  endfunction

  assign w_capture = (r_state == S_CAPTURE);

  // Round-robin pick: scan from farthest to nearest so the nearest requester at or after ptr wins.
  always_comb begin
    w_any        = 1'b0;
    w_winner     = '0;
    w_status_sel = 8'h00;
    for (int k = N_STATIONS - 1; k >= 0; k--) begin
      w_any        = w_any | bus.req[wrap_idx(int'(r_ptr), k)];
      w_winner     = bus.req[wrap_idx(int'(r_ptr), k)] ? IW'(wrap_idx(int'(r_ptr), k)) : w_winner;
      w_status_sel = bus.req[wrap_idx(int'(r_ptr), k)] ?
                     bus.status_in[8*wrap_idx(int'(r_ptr), k) +: 8] : w_status_sel;
    end
  end

  // Transaction FSM with registered scorer drive, result outputs, pointer and sticky alarm.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_idx           <= '0;
      r_proc_status   <= 8'h00;
      r_score_out     <= 16'h0000;
      r_score_station <= '0;
      r_ack           <= '0;
      r_score_valid   <= 1'b0;
      r_crit_alarm    <= 1'b0;
    end else begin
      r_ack         <= '0;
      r_score_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_proc_status <= w_status_sel;
            r_idx         <= w_winner;
            r_state       <= S_SETTLE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_score_out     <= i_proc_score;
          r_score_station <= r_idx;
          r_score_valid   <= 1'b1;
          r_ack[r_idx]    <= 1'b1;
          if (r_idx == IW'(N_STATIONS - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_idx + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // A critical capture takes priority over a clear in the same cycle.
      if (w_capture && (i_proc_score == 16'h8000)) begin
        r_crit_alarm <= 1'b1;
      end else if (bus.alarm_clr) begin
        r_crit_alarm <= 1'b0;
      end else begin
        r_crit_alarm <= r_crit_alarm;
      end
    end
  end

  assign o_proc_status     = r_proc_status;
  assign bus.score_out     = r_score_out;
  assign bus.score_station = r_score_station;
  assign bus.ack           = r_ack;
  assign bus.score_valid   = r_score_valid;
  assign bus.crit_alarm    = r_crit_alarm;

`ifdef CREW_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]         r_wd_cnt [N_STATIONS];
  logic [N_STATIONS-1:0] r_stale;

  // Per-station saturating age counters; cleared on the edge that raises that station's ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_STATIONS; i++) begin
        r_wd_cnt[i] <= '0;
      end
      r_stale <= '0;
    end else begin
      for (int i = 0; i < N_STATIONS; i++) begin
        if (w_capture && (r_idx == IW'(i))) begin
          r_wd_cnt[i] <= '0;
          r_stale[i]  <= 1'b0;
        end else if (r_wd_cnt[i] == CW'(TIMEOUT)) begin
          r_wd_cnt[i] <= r_wd_cnt[i];
          r_stale[i]  <= 1'b1;
        end else begin
          r_wd_cnt[i] <= r_wd_cnt[i] + 1'b1;
          r_stale[i]  <= ((r_wd_cnt[i] + 1'b1) == CW'(TIMEOUT));
        end
      end
    end
  end

  assign bus.stale = r_stale;
`else
  assign bus.stale = '0;
`endif

endmodule

// File: tb/tb_crew_status_scheduler.sv
// Directed self-checking bench for crew_status_scheduler with N_STATIONS=4, TIMEOUT=8.
// A small scorer model stands in for personnel_processor: one register stage, and each
// 2-bit crew field reading 2'b00 contributes a fixed risk weight.
module tb_crew_status_scheduler;

  logic        clk;
  logic        rst;
  logic [7:0]  proc_status;
  logic [15:0] proc_score;
  int          checks;
  int          failures;

  crew_status_scheduler_if #(.N_STATIONS(4)) bus ();

  crew_status_scheduler #(
    .N_STATIONS (4),
    .TIMEOUT    (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_proc_status (proc_status),
    .i_proc_score  (proc_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scorer model weights: field [7:6]->8000, [5:4]->4000, [3:2]->0800, [1:0]->0400.
  function automatic logic [15:0] score_f(input logic [7:0] s);
    logic [15:0] r;
    r = 16'h0000;
    if (s[7:6] == 2'b00) r = r | 16'h8000;
    if (s[5:4] == 2'b00) r = r | 16'h4000;
    if (s[3:2] == 2'b00) r = r | 16'h0800;
    if (s[1:0] == 2'b00) r = r | 16'h0400;
    return r;
  endfunction

  always @(posedge clk) proc_score <= score_f(proc_status);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req       = 4'b0000;
    bus.status_in = 32'h0000_0000;
    bus.alarm_clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({proc_status, bus.score_out, bus.score_station, bus.ack, bus.score_valid,
         bus.crit_alarm, bus.stale} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ps=%h so=%h st=%0d ack=%b sv=%b ca=%b stale=%b, required all 0",
               proc_status, bus.score_out, bus.score_station, bus.ack, bus.score_valid,
               bus.crit_alarm, bus.stale);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.status_in = 32'h00FF_0000;
    bus.req       = 4'b0100;
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b0000 || proc_status !== 8'hFF) begin
      failures++;
      $display("FAIL single_early: got ack=%b ps=%h, required ack=0000 ps=ff", bus.ack, proc_status);
    end
    tick();
    checks++;
    if (bus.ack !== 4'b0100 || bus.score_valid !== 1'b1 || bus.score_out !== 16'h0000 ||
        bus.score_station !== 2'd2 || bus.crit_alarm !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got ack=%b sv=%b so=%h st=%0d ca=%b, required 0100 1 0000 2 0",
               bus.ack, bus.score_valid, bus.score_out, bus.score_station, bus.crit_alarm);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.ack !== 4'b0000 || bus.score_valid !== 1'b0 || bus.score_out !== 16'h0000) begin
      failures++;
      $display("FAIL single_pulse_end: got ack=%b sv=%b so=%h, required 0000 0 0000",
               bus.ack, bus.score_valid, bus.score_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_score [4];
    exp_score[0] = 16'h8000;
    exp_score[1] = 16'h4000;
    exp_score[2] = 16'h0800;
    exp_score[3] = 16'h0400;
    do_reset();
    bus.status_in = 32'hFCF3_CF3F;
    bus.req       = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      checks++;
      if (bus.ack !== 4'b0000 || bus.crit_alarm !== (k != 0)) begin
        failures++;
        $display("FAIL b2b_gap%0d: got ack=%b ca=%b, required ack=0000 ca=%0d",
                 k, bus.ack, bus.crit_alarm, (k != 0));
      end
      tick();
      checks++;
      if (bus.ack !== (4'b0001 << k) || bus.score_valid !== 1'b1 || bus.score_station !== k[1:0] ||
          bus.score_out !== exp_score[k] || bus.crit_alarm !== 1'b1) begin
        failures++;
        $display("FAIL b2b_grant%0d: got ack=%b sv=%b st=%0d so=%h ca=%b, required ack=%b sv=1 st=%0d so=%h ca=1",
                 k, bus.ack, bus.score_valid, bus.score_station, bus.score_out, bus.crit_alarm,
                 (4'b0001 << k), k, exp_score[k]);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_alarm_clr();
    do_reset();
    bus.status_in = 32'h0000_003F;
    bus.req       = 4'b0001;
    tick();
    tick();
    bus.alarm_clr = 1'b1;
    tick();
    checks++;
    if (bus.crit_alarm !== 1'b1 || bus.ack !== 4'b0001) begin
      failures++;
      $display("FAIL alarm_set_wins: got ca=%b ack=%b, required ca=1 ack=0001", bus.crit_alarm, bus.ack);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.crit_alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_clear: got ca=%b, required 0", bus.crit_alarm);
    end
    bus.alarm_clr = 1'b0;
  endtask

  task automatic test_snapshot();
    do_reset();
    bus.status_in = 32'h0000_FF00;
    bus.req       = 4'b0010;
    tick();
    bus.status_in = 32'h0000_3F00;
    tick();
    checks++;
    if (proc_status !== 8'hFF) begin
      failures++;
      $display("FAIL snapshot_status: got ps=%h, required ff", proc_status);
    end
    tick();
    checks++;
    if (bus.ack !== 4'b0010 || bus.score_out !== 16'h0000 || bus.crit_alarm !== 1'b0) begin
      failures++;
      $display("FAIL snapshot_score: got ack=%b so=%h ca=%b, required 0010 0000 0",
               bus.ack, bus.score_out, bus.crit_alarm);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.status_in = 32'h3F00_FF00;
    bus.req       = 4'b1010;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({proc_status, bus.score_out, bus.score_station, bus.ack, bus.score_valid,
         bus.crit_alarm, bus.stale} !== 41'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got ps=%h so=%h st=%0d ack=%b sv=%b ca=%b stale=%b, required all 0",
               proc_status, bus.score_out, bus.score_station, bus.ack, bus.score_valid,
               bus.crit_alarm, bus.stale);
    end
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_no_ack: got ack=%b, required 0000", bus.ack);
    end
    tick();
    checks++;
    if (bus.ack !== 4'b0010 || bus.score_station !== 2'd1 || bus.score_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_first: got ack=%b st=%0d so=%h, required 0010 1 0000",
               bus.ack, bus.score_station, bus.score_out);
    end
    tick();
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b1000 || bus.score_station !== 2'd3 || bus.score_out !== 16'h8000) begin
      failures++;
      $display("FAIL reset_mid_second: got ack=%b st=%0d so=%h, required 1000 3 8000",
               bus.ack, bus.score_station, bus.score_out);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_watchdog();
    do_reset();
`ifdef CREW_SCHED_WATCHDOG_EN
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (bus.stale[3] !== 1'b0) begin
      failures++;
      $display("FAIL wd_before_limit: got stale3=%b, required 0", bus.stale[3]);
    end
    tick();
    checks++;
    if (bus.stale !== 4'b1111) begin
      failures++;
      $display("FAIL wd_at_limit: got stale=%b, required 1111", bus.stale);
    end
    bus.status_in = 32'hFF00_0000;
    bus.req       = 4'b1000;
    tick();
    tick();
    checks++;
    if (bus.stale[3] !== 1'b1) begin
      failures++;
      $display("FAIL wd_saturated: got stale3=%b, required 1", bus.stale[3]);
    end
    tick();
    checks++;
    if (bus.ack !== 4'b1000 || bus.stale !== 4'b0111) begin
      failures++;
      $display("FAIL wd_ack_clears: got ack=%b stale=%b, required 1000 0111", bus.ack, bus.stale);
    end
    bus.req = 4'b0000;
`else
    bus.status_in = 32'hFF00_0000;
    bus.req       = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (bus.stale !== 4'b0000) begin
        failures++;
        $display("FAIL wd_disabled_c%0d: got stale=%b, required 0000", k, bus.stale);
      end
    end
    bus.req = 4'b0000;
`endif
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.req       = 4'b0000;
    bus.status_in = 32'h0000_0000;
    bus.alarm_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_alarm_clr();
    test_snapshot();
    test_reset_mid();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
